// File: rtl/hazard_stall_ctrl_if.sv
// rtl/hazard_stall_ctrl_if.sv - pipeline-side decode/EX status in, PC and pipe-register enables out
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       id_opcode;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic [4:0]       ex_rd;
  logic             ex_memread;
  logic             ex_mac;
  logic             ex_redirect;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             idex_hold;
  logic             exmem_bubble;
  logic             mac_busy;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] redirect_count;

  modport master (
    output id_opcode, id_rs1, id_rs2, ex_rd, ex_memread, ex_mac, ex_redirect,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_bubble,
    input  mac_busy, stall_cycles, redirect_count
  );

  modport slave (
    input  id_opcode, id_rs1, id_rs2, ex_rd, ex_memread, ex_mac, ex_redirect,
    output pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_bubble,
    output mac_busy, stall_cycles, redirect_count
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use/redirect/MAC stall sequencer for the 5-stage core
// Define PERF_CNT_EN to add saturating stall and redirect counters.
module hazard_stall_ctrl #(
  parameter int MAC_LAT = 3,
  parameter int CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  hazard_stall_ctrl_if.slave   bus
);
  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MAC_BUSY = 1'b1;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_RCC   = 7'b0110011;
  localparam logic [6:0] OP_SCC   = 7'b0100011;
  localparam logic [6:0] OP_BCC   = 7'b1100011;
  localparam logic [6:0] OP_MAC   = 7'b1111111;

  localparam logic       MAC_MULTI    = (MAC_LAT > 1);
  localparam logic [3:0] MAC_CNT_INIT = 4'(MAC_LAT - 1);

  logic [0:0] state;
  logic [3:0] cnt;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       load_use;
  logic       mac_stall;
  logic       mac_start;

  always_comb begin
    uses_rs1 = !(bus.id_opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
    uses_rs2 = bus.id_opcode inside {OP_RCC, OP_SCC, OP_BCC, OP_MAC};
    load_use = bus.ex_memread && (bus.ex_rd != 5'd0) &&
               ((uses_rs1 && (bus.ex_rd == bus.id_rs1)) ||
                (uses_rs2 && (bus.ex_rd == bus.id_rs2)));
  end

  // The release cycle (cnt==1) ignores ex_mac: the finishing MAC is still in EX.
  assign mac_start = (state == RUN) && bus.ex_mac && MAC_MULTI;
  assign mac_stall = mac_start || ((state == MAC_BUSY) && (cnt > 4'd1));

  always_comb begin
    bus.pc_write     = 1'b1;
    bus.ifid_write   = 1'b1;
    bus.ifid_flush   = 1'b0;
    bus.idex_bubble  = 1'b0;
    bus.idex_hold    = 1'b0;
    bus.exmem_bubble = 1'b0;
    bus.mac_busy     = (state == MAC_BUSY);
    if (!reset) begin
      bus.pc_write     = 1'b0;
      bus.ifid_write   = 1'b0;
      bus.ifid_flush   = 1'b1;
      bus.idex_bubble  = 1'b1;
      bus.exmem_bubble = 1'b1;
      bus.mac_busy     = 1'b0;
    end else if (mac_stall) begin
      bus.pc_write     = 1'b0;
      bus.ifid_write   = 1'b0;
      bus.idex_hold    = 1'b1;
      bus.exmem_bubble = 1'b1;
    end else if (bus.ex_redirect) begin
      bus.ifid_flush   = 1'b1;
      bus.idex_bubble  = 1'b1;
    end else if (load_use) begin
      bus.pc_write     = 1'b0;
      bus.ifid_write   = 1'b0;
      bus.idex_bubble  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else if (mac_start) begin
      state <= MAC_BUSY;
      cnt   <= MAC_CNT_INIT;
    end else if (state == MAC_BUSY) begin
      if (cnt > 4'd1) begin
        cnt <= cnt - 4'd1;
      end else begin
        state <= RUN;
        cnt   <= 4'd0;
      end
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] redirect_q;
  logic             redirect_acc;

  assign redirect_acc = bus.ex_redirect && !mac_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q    <= '0;
      redirect_q <= '0;
    end else begin
      if (!bus.pc_write && (stall_q != '1))
        stall_q <= stall_q + 1'b1;
      if (redirect_acc && (redirect_q != '1))
        redirect_q <= redirect_q + 1'b1;
    end
  end

  assign bus.stall_cycles   = stall_q;
  assign bus.redirect_count = redirect_q;
`else
  assign bus.stall_cycles   = '0;
  assign bus.redirect_count = '0;
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed checks of hazard_stall_ctrl with MAC_LAT=3 and MAC_LAT=1
module tb_hazard_stall_ctrl;
  localparam int CNT_W = 32;
`ifdef PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Output vector order: pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_bubble, mac_busy
  localparam logic [6:0] V_RST  = 7'b0011010;
  localparam logic [6:0] V_DEF  = 7'b1100000;
  localparam logic [6:0] V_LU   = 7'b0001000;
  localparam logic [6:0] V_RED  = 7'b1111000;
  localparam logic [6:0] V_MAC0 = 7'b0000110;
  localparam logic [6:0] V_MACB = 7'b0000111;
  localparam logic [6:0] V_REL  = 7'b1100001;

  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_RCC = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  hazard_stall_ctrl_if #(.CNT_W(CNT_W)) if3 ();
  hazard_stall_ctrl_if #(.CNT_W(CNT_W)) if1 ();

  hazard_stall_ctrl #(.MAC_LAT(3), .CNT_W(CNT_W)) dut3 (.clk(clk), .reset(reset), .bus(if3));
  hazard_stall_ctrl #(.MAC_LAT(1), .CNT_W(CNT_W)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  assign if1.id_opcode   = if3.id_opcode;
  assign if1.id_rs1      = if3.id_rs1;
  assign if1.id_rs2      = if3.id_rs2;
  assign if1.ex_rd       = if3.ex_rd;
  assign if1.ex_memread  = if3.ex_memread;
  assign if1.ex_mac      = if3.ex_mac;
  assign if1.ex_redirect = if3.ex_redirect;

  wire [6:0] o3 = {if3.pc_write, if3.ifid_write, if3.ifid_flush, if3.idex_bubble,
                   if3.idex_hold, if3.exmem_bubble, if3.mac_busy};
  wire [6:0] o1 = {if1.pc_write, if1.ifid_write, if1.ifid_flush, if1.idex_bubble,
                   if1.idex_hold, if1.exmem_bubble, if1.mac_busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic memrd, input logic mac, input logic redir);
    @(negedge clk);
    if3.id_opcode   = op;
    if3.id_rs1      = rs1;
    if3.id_rs2      = rs2;
    if3.ex_rd       = rd;
    if3.ex_memread  = memrd;
    if3.ex_mac      = mac;
    if3.ex_redirect = redir;
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    if3.id_opcode = 7'd0; if3.id_rs1 = 5'd0; if3.id_rs2 = 5'd0; if3.ex_rd = 5'd0;
    if3.ex_memread = 1'b0; if3.ex_mac = 1'b0; if3.ex_redirect = 1'b0;
    #2;
    chk("reset_out3", o3, V_RST);
    chk("reset_out1", o1, V_RST);
    chk("reset_stall_cnt", if3.stall_cycles, 0);
    chk("reset_redir_cnt", if3.redirect_count, 0);

    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("run_default", o3, V_DEF);

    // Load-use on rs2 of an R-type
    drive(OP_RCC, 5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0);
    chk("lu_rs2", o3, V_LU);
    drive(OP_RCC, 5'd1, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0);
    chk("lu_after", o3, V_DEF);
    chk("lu_stall_cnt", if3.stall_cycles, PERF ? 1 : 0);

    // No hazard: x0, LUI ignores rs1, I-type ignores rs2
    drive(OP_RCC, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("lu_x0", o3, V_DEF);
    drive(OP_LUI, 5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
    chk("lu_lui", o3, V_DEF);
    drive(OP_IMM, 5'd1, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0);
    chk("lu_imm_rs2", o3, V_DEF);
    drive(OP_IMM, 5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
    chk("lu_imm_rs1", o3, V_LU);

    // Redirect overrides a simultaneous load-use
    drive(OP_RCC, 5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1);
    chk("redirect_lu", o3, V_RED);
    drive(7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("redirect_after", o3, V_DEF);
    chk("redir_cnt", if3.redirect_count, PERF ? 1 : 0);
    chk("redir_stall_cnt", if3.stall_cycles, PERF ? 2 : 0);

    // MAC with MAC_LAT=3: two stall cycles, release on the third
    drive(7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("mac_start3", o3, V_MAC0);
    chk("mac_start1", o1, V_DEF);
    drive(7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    chk("mac_busy_redir3", o3, V_MACB);
    chk("mac_redir1", o1, V_RED);
    drive(7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("mac_release3", o3, V_REL);
    chk("mac_release1", o1, V_DEF);

    // Back-to-back MAC restarts the sequence
    drive(7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("mac_restart3", o3, V_MAC0);
    chk("mac_stall_cnt3", if3.stall_cycles, PERF ? 4 : 0);
    chk("mac_redir_cnt3", if3.redirect_count, PERF ? 1 : 0);
    chk("mac_stall_cnt1", if1.stall_cycles, PERF ? 2 : 0);
    chk("mac_redir_cnt1", if1.redirect_count, PERF ? 2 : 0);
    drive(7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("mac_busy_again", o3, V_MACB);

    // Async reset mid-MAC (cnt=2)
    reset = 1'b0;
    #1;
    chk("midmac_reset", o3, V_RST);
    chk("midmac_reset_cnt", if3.stall_cycles, 0);
    @(negedge clk);
    reset = 1'b1;
    if3.ex_mac = 1'b0;
    #1;
    chk("post_reset", o3, V_DEF);
    drive(7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("post_reset_run", o3, V_DEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
